// File: rtl/uart_cmd_parser.sv
// Framed command decoder behind uart_rx: SYNC, OPCODE, LEN, LEN words of payload, XOR checksum.
// Emits a header pulse, a valid/ready payload word stream and a per-frame completion status.
module uart_cmd_parser #(
  parameter int         WORD_BYTES   = 4,
  parameter int         WORD_W       = 32,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 64,
  parameter int         TIMEOUT_CLKS = 50_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              hdr_valid,
  output logic [7:0]        hdr_opcode,
  output logic [7:0]        hdr_len,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_last,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              err_overrun,
  output logic              err_timeout,
  output logic              busy
);

  localparam int BCNT_W = $clog2(MAX_LEN * WORD_BYTES + 1);
  localparam int WCNT_W = $clog2(MAX_LEN + 1);
  localparam int BIW_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CLKS);

  localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [BCNT_W-1:0] WB_B      = BCNT_W'(WORD_BYTES);
  localparam logic [BIW_W-1:0]  BIW_LAST  = BIW_W'(WORD_BYTES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    OPCODE,
    LEN,
    PAYLOAD,
    CHECK
  } state_t;

  state_t              state;
  logic [7:0]          op_reg;
  logic [7:0]          chk;
  logic [WORD_W-1:0]   asm_reg;
  logic [BCNT_W-1:0]   byte_cnt;
  logic [BCNT_W-1:0]   frame_bytes;
  logic [BIW_W-1:0]    biw;
  logic [WCNT_W-1:0]   word_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                ovr_flag;

  logic                tmo_hit;
  logic                byte_last;
  logic                word_done;
  logic                word_is_last;
  logic                out_free;
  logic [WORD_W-1:0]   asm_next;

  // Little-endian assembly: the first byte of a word ends up in bits [7:0].
  function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] cur,
                                                 input logic [7:0]        b);
    return {b, cur[WORD_W-1:8]};
  endfunction

  always_comb begin
    tmo_hit      = (state != IDLE) && (tmo_cnt == TMO_LAST);
    byte_last    = (byte_cnt == (frame_bytes - BCNT_W'(1)));
    word_done    = (biw == BIW_LAST);
    word_is_last = ((8'(word_cnt) + 8'd1) == hdr_len);
    out_free     = !word_valid || word_ready;
    asm_next     = shift_in(asm_reg, rx_data);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      op_reg      <= '0;
      chk         <= '0;
      asm_reg     <= '0;
      byte_cnt    <= '0;
      frame_bytes <= '0;
      biw         <= '0;
      word_cnt    <= '0;
      tmo_cnt     <= '0;
      ovr_flag    <= 1'b0;
      hdr_valid   <= 1'b0;
      hdr_opcode  <= '0;
      hdr_len     <= '0;
      word_valid  <= 1'b0;
      word_data   <= '0;
      word_last   <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      hdr_valid   <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;

      // The output word drains independently of the frame state, so a word
      // pending when a frame times out is still delivered.
      if (word_valid && word_ready) begin
        word_valid <= 1'b0;
        word_last  <= 1'b0;
      end

      if (rx_valid) begin
        tmo_cnt <= '0;
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end

      if (tmo_hit) begin
        state       <= IDLE;
        busy        <= 1'b0;
        tmo_cnt     <= '0;
        frame_done  <= 1'b1;
        err_timeout <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state <= OPCODE;
              busy  <= 1'b1;
            end
          end

          OPCODE: begin
            op_reg <= rx_data;
            chk    <= rx_data;
            state  <= LEN;
          end

          LEN: begin
            chk <= chk ^ rx_data;
            if (rx_data > MAX_LEN_B) begin
              frame_done <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              hdr_opcode  <= op_reg;
              hdr_len     <= rx_data;
              hdr_valid   <= 1'b1;
              frame_bytes <= BCNT_W'(rx_data) * WB_B;
              byte_cnt    <= '0;
              biw         <= '0;
              word_cnt    <= '0;
              ovr_flag    <= 1'b0;
              state       <= (rx_data == 8'd0) ? CHECK : PAYLOAD;
            end
          end

          PAYLOAD: begin
            chk      <= chk ^ rx_data;
            asm_reg  <= asm_next;
            byte_cnt <= byte_cnt + BCNT_W'(1);
            if (word_done) begin
              biw      <= '0;
              word_cnt <= word_cnt + WCNT_W'(1);
              // A held word is never overwritten; the new one is dropped instead.
              if (out_free) begin
                word_data  <= asm_next;
                word_valid <= 1'b1;
                word_last  <= word_is_last;
              end else begin
                err_overrun <= 1'b1;
                ovr_flag    <= 1'b1;
              end
            end else begin
              biw <= biw + BIW_W'(1);
            end
            if (byte_last) begin
              state <= CHECK;
            end
          end

          CHECK: begin
            frame_done <= 1'b1;
            frame_ok   <= (rx_data == chk) && !ovr_flag;
            state      <= IDLE;
            busy       <= 1'b0;
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: table of whole frames plus hand-written
// overrun, timeout, oversize and asynchronous-reset sequences.
module tb_uart_cmd_parser;

  localparam int TMO = 200;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        hdr_valid;
  logic [7:0]  hdr_opcode;
  logic [7:0]  hdr_len;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic        word_last;
  logic        frame_done;
  logic        frame_ok;
  logic        err_overrun;
  logic        err_timeout;
  logic        busy;

  uart_cmd_parser #(
    .WORD_BYTES  (4),
    .WORD_W      (32),
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (64),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .hdr_valid  (hdr_valid),
    .hdr_opcode (hdr_opcode),
    .hdr_len    (hdr_len),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_last  (word_last),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .err_overrun(err_overrun),
    .err_timeout(err_timeout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor, sampled on the falling edge.
  int          hdr_cnt  = 0;
  int          done_cnt = 0;
  int          ovr_cnt  = 0;
  int          tmo_cnt  = 0;
  logic        last_ok  = 1'b0;
  logic [32:0] wq[$];

  always @(negedge clk) begin
    if (hdr_valid) hdr_cnt++;
    if (frame_done) begin
      done_cnt++;
      last_ok = frame_ok;
    end
    if (err_overrun) ovr_cnt++;
    if (err_timeout) tmo_cnt++;
    if (word_valid && word_ready) wq.push_back({word_last, word_data});
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  bytes [16];
    int          n;
    logic [7:0]  op;
    logic [7:0]  len;
    int          nwords;
    logic [31:0] w0;
    logic        l0;
    logic [31:0] w1;
    logic        l1;
    logic        ok;
  } vec_t;

  vec_t vecs [4];

  task automatic send_vec(input int v);
    for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].bytes[k]);
  endtask

  int          h0, d0, o0, t0, q0, gap;
  logic [32:0] wv;
  bit          seen;

  initial begin
    vecs[0].bytes = '{8'hA5, 8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[0].n = 8;  vecs[0].op = 8'h10; vecs[0].len = 8'd1; vecs[0].nwords = 1;
    vecs[0].w0 = 32'h44332211; vecs[0].l0 = 1'b1; vecs[0].w1 = '0; vecs[0].l1 = 1'b0;
    vecs[0].ok = 1'b1;

    vecs[1].bytes = '{8'hA5, 8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h54,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1].n = 8;  vecs[1].op = 8'h10; vecs[1].len = 8'd1; vecs[1].nwords = 1;
    vecs[1].w0 = 32'h44332211; vecs[1].l0 = 1'b1; vecs[1].w1 = '0; vecs[1].l1 = 1'b0;
    vecs[1].ok = 1'b0;

    vecs[2].bytes = '{8'h00, 8'hFF, 8'hA5, 8'h20, 8'h00, 8'h20, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].n = 6;  vecs[2].op = 8'h20; vecs[2].len = 8'd0; vecs[2].nwords = 0;
    vecs[2].w0 = '0; vecs[2].l0 = 1'b0; vecs[2].w1 = '0; vecs[2].l1 = 1'b0;
    vecs[2].ok = 1'b1;

    // Two words, with a SYNC value inside the payload treated as data.
    vecs[3].bytes = '{8'hA5, 8'h30, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA5,
                      8'hB6, 8'hC7, 8'hD8, 8'h3A, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].n = 12; vecs[3].op = 8'h30; vecs[3].len = 8'd2; vecs[3].nwords = 2;
    vecs[3].w0 = 32'h04030201; vecs[3].l0 = 1'b0; vecs[3].w1 = 32'hD8C7B6A5; vecs[3].l1 = 1'b1;
    vecs[3].ok = 1'b1;

    rst        = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    word_ready = 1'b1;
    idle_cycles(3);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_word_valid", 64'(word_valid), 64'd0);
    check("rst_hdr_valid",  64'(hdr_valid),  64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_hdr_opcode", 64'(hdr_opcode), 64'd0);
    check("rst_word_data",  64'(word_data),  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(2);

    for (int v = 0; v < 4; v++) begin
      h0 = hdr_cnt; d0 = done_cnt; o0 = ovr_cnt; q0 = wq.size();
      send_vec(v);
      idle_cycles(4);
      check($sformatf("v%0d_hdr_cnt", v),  64'(hdr_cnt - h0),    64'd1);
      check($sformatf("v%0d_opcode", v),   64'(hdr_opcode),      64'(vecs[v].op));
      check($sformatf("v%0d_len", v),      64'(hdr_len),         64'(vecs[v].len));
      check($sformatf("v%0d_nwords", v),   64'(wq.size() - q0),  64'(vecs[v].nwords));
      if (vecs[v].nwords > 0 && wq.size() > q0) begin
        wv = wq[q0];
        check($sformatf("v%0d_w0", v), 64'(wv[31:0]), 64'(vecs[v].w0));
        check($sformatf("v%0d_l0", v), 64'(wv[32]),   64'(vecs[v].l0));
      end
      if (vecs[v].nwords > 1 && wq.size() > q0 + 1) begin
        wv = wq[q0 + 1];
        check($sformatf("v%0d_w1", v), 64'(wv[31:0]), 64'(vecs[v].w1));
        check($sformatf("v%0d_l1", v), 64'(wv[32]),   64'(vecs[v].l1));
      end
      check($sformatf("v%0d_done_cnt", v), 64'(done_cnt - d0), 64'd1);
      check($sformatf("v%0d_frame_ok", v), 64'(last_ok),       64'(vecs[v].ok));
      check($sformatf("v%0d_overrun", v),  64'(ovr_cnt - o0),  64'd0);
      check($sformatf("v%0d_busy", v),     64'(busy),          64'd0);
    end

    // Overrun: consumer stalled across two word completions.
    word_ready = 1'b0;
    h0 = hdr_cnt; d0 = done_cnt; o0 = ovr_cnt; q0 = wq.size();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    send_byte(8'h9A);
    idle_cycles(3);
    check("ovr_err_cnt",    64'(ovr_cnt - o0),   64'd1);
    check("ovr_done_cnt",   64'(done_cnt - d0),  64'd1);
    check("ovr_frame_ok",   64'(last_ok),        64'd0);
    check("ovr_none_taken", 64'(wq.size() - q0), 64'd0);
    check("ovr_held_valid", 64'(word_valid),     64'd1);
    check("ovr_held_data",  64'(word_data),      64'h44332211);
    check("ovr_held_last",  64'(word_last),      64'd0);
    @(posedge clk);
    #1;
    word_ready = 1'b1;
    idle_cycles(4);
    check("ovr_drain_cnt", 64'(wq.size() - q0), 64'd1);
    if (wq.size() > q0) begin
      wv = wq[q0];
      check("ovr_drain_word", 64'(wv), {31'd0, 1'b0, 32'h44332211});
    end
    check("ovr_valid_low", 64'(word_valid), 64'd0);

    // Timeout: frame stops after the first payload byte.
    d0 = done_cnt; t0 = tmo_cnt;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
    seen = 1'b0;
    gap  = 0;
    for (int i = 0; i < TMO + 20; i++) begin
      @(negedge clk);
      if (i == 2) check("tmo_busy_before", 64'(busy), 64'd1);
      if (err_timeout) begin
        seen = 1'b1;
        gap  = i;
        check("tmo_done_with_err", 64'(frame_done), 64'd1);
        check("tmo_ok_low",        64'(frame_ok),   64'd0);
        check("tmo_busy_after",    64'(busy),       64'd0);
        break;
      end
    end
    check("tmo_seen", 64'(seen), 64'd1);
    check("tmo_gap_in_window", 64'((gap >= TMO - 1) && (gap <= TMO + 1)), 64'd1);
    idle_cycles(2);
    check("tmo_err_cnt", 64'(tmo_cnt - t0), 64'd1);
    q0 = wq.size();
    send_vec(0);
    idle_cycles(4);
    check("tmo_next_ok",   64'(last_ok),        64'd1);
    check("tmo_next_word", 64'(wq.size() - q0), 64'd1);

    // Oversize LEN: immediate failed completion, no header.
    h0 = hdr_cnt; d0 = done_cnt;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h41);
    idle_cycles(3);
    check("big_hdr_cnt",  64'(hdr_cnt - h0),  64'd0);
    check("big_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("big_frame_ok", 64'(last_ok),       64'd0);
    check("big_busy",     64'(busy),          64'd0);
    check("big_len_kept", 64'(hdr_len),       64'd1);

    // Asynchronous reset mid-payload with a word pending.
    word_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    idle_cycles(1);
    check("ar_pre_valid", 64'(word_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_word_valid", 64'(word_valid), 64'd0);
    check("ar_word_data",  64'(word_data),  64'd0);
    check("ar_hdr_opcode", 64'(hdr_opcode), 64'd0);
    check("ar_hdr_len",    64'(hdr_len),    64'd0);
    check("ar_busy",       64'(busy),       64'd0);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    word_ready = 1'b1;
    q0 = wq.size();
    send_vec(0);
    idle_cycles(4);
    check("ar_next_ok",   64'(last_ok),        64'd1);
    check("ar_next_word", 64'(wq.size() - q0), 64'd1);
    if (wq.size() > q0) begin
      wv = wq[q0];
      check("ar_next_data", 64'(wv), {31'd0, 1'b1, 32'h44332211});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes the byte stream produced by the UART receiver (one-cycle `data_valid` strobe plus an 8-bit byte) and decodes framed accelerator commands.
- Frame format: SYNC, OPCODE, LEN, then LEN×WORD_BYTES payload bytes, then CHK.
- Emits a command header, payload words over a valid/ready stream to the vector accelerator, and a per-frame completion status.
- Sits directly downstream of uart_rx and upstream of the command dispatcher.

Parameters:
- WORD_BYTES, 4, payload bytes per output word (little-endian assembly, first byte → bits [7:0]).
- WORD_W, 32, output word width; must equal 8×WORD_BYTES.
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 64, largest legal LEN value (in words).
- TIMEOUT_CLKS, 50_000, maximum clk cycles allowed between bytes inside a frame.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- rx_valid  in  1  byte strobe from uart_rx data_valid; one cycle wide; cannot be back-pressured
- rx_data  in  8  byte from uart_rx data_out
- hdr_valid  out  1  one-cycle pulse; header has been decoded
- hdr_opcode  out  8  opcode; held until the next header
- hdr_len  out  8  LEN field; held until the next header
- word_valid  out  1  payload word available
- word_ready  in  1  consumer accepts word
- word_data  out  WORD_W  payload word
- word_last  out  1  marks the final word of the frame; qualified by word_valid
- frame_done  out  1  one-cycle pulse; frame terminated
- frame_ok  out  1  frame status, qualified by frame_done
- err_overrun  out  1  one-cycle pulse; completed word dropped
- err_timeout  out  1  one-cycle pulse; inter-byte gap exceeded
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: async clear. state=IDLE. All outputs 0: hdr_opcode, hdr_len, word_data, word_last, all pulses, busy. Checksum, byte counter, word counter and timeout counter cleared. A reset mid-frame discards everything, including a pending output word.
- FSM states: IDLE, OPCODE, LEN, PAYLOAD, CHECK. All transitions occur on a cycle with rx_valid=1, except timeout.
  - IDLE: rx_data==SYNC_BYTE → OPCODE. Any other byte is ignored.
  - OPCODE: latch the opcode; chk = rx_data → LEN.
  - LEN: chk ^= rx_data.
    - rx_data > MAX_LEN: frame_done=1, frame_ok=0 → IDLE. No hdr_valid.
    - Otherwise: latch hdr_opcode/hdr_len and pulse hdr_valid the next cycle. Go to PAYLOAD, or to CHECK if LEN=0.
  - PAYLOAD: chk ^= byte; shift the byte into the assembly register.
    - On the WORD_BYTES-th byte of a word, the word is complete.
    - After LEN×WORD_BYTES bytes → CHECK.
    - SYNC_BYTE values in the payload are ordinary data; there is no escaping.
  - CHECK: compare rx_data with chk. Pulse frame_done the next cycle, with frame_ok = (match && no overrun this frame) → IDLE.
- Word output:
  - A completed word loads the output register and sets word_valid the cycle after the rx_valid of its last byte.
  - word_last=1 iff it is word LEN of the frame.
  - word_valid holds until a cycle with word_ready=1.
  - Completion while word_valid=1 and word_ready=0: new word dropped, err_overrun pulses, frame flagged bad, the old word is kept.
  - Completion in the same cycle as a word_valid&&word_ready handshake: not an overrun; the new word loads.
- Timeout:
  - The counter clears on every rx_valid and increments every cycle while state != IDLE.
  - On reaching TIMEOUT_CLKS-1: err_timeout=1, frame_done=1, frame_ok=0 → IDLE.
  - A pending output word is retained and is still delivered.
- Width rules:
  - Byte counter spans MAX_LEN×WORD_BYTES.
  - Timeout counter is $clog2(TIMEOUT_CLKS) bits.
  - chk is an 8-bit XOR over OPCODE, LEN and all payload bytes.
- Priority when events coincide: reset > timeout > byte processing.

Test Plan:
1. Normal frame: bytes A5 10 01 11 22 33 44 55 → hdr_valid with opcode=0x10, len=1; one word 0x44332211 with word_last=1; frame_done with frame_ok=1.
2. Bad checksum: same frame ending in 0x54 instead of 0x55 → word 0x44332211 still delivered; frame_done with frame_ok=0.
3. Resync and zero length: 00 FF A5 20 00 20 → leading bytes ignored; hdr opcode=0x20, len=0; no word_valid; frame_ok=1.
4. Overrun: word_ready=0, frame A5 10 02 + 8 payload bytes + correct chk → first word held; err_overrun on 2nd word; frame_ok=0. Raise word_ready → only the first word is seen.
5. Timeout: A5 10 02 11, then idle → err_timeout and frame_done/frame_ok=0 after TIMEOUT_CLKS cycles; busy drops; next frame from case 1 parses with frame_ok=1.
6. Oversize and reset: A5 10 41 → immediate frame_done, frame_ok=0, no hdr_valid. Separately, asserting rst low mid-payload → all outputs 0 asynchronously and state=IDLE.
